// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, clock divisor helper and frame constants.
// Common to the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake between a producer (master) and the UART transmitter (slave).
// A byte moves on any clock edge where data_valid and data_ready are both high.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 data_valid;
    logic                 data_ready;
    logic [DATA_BITS-1:0] data_byte;

    modport master (output data_valid, output data_byte, input data_ready);
    modport slave  (input data_valid, input data_byte, output data_ready);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..DIV-1 and wraps; restart_i forces zero on the next clock.
// bit_done_o is high during the final clock of each bit period.
module uart_baud_counter #(
    parameter int DIV = 450
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic bit_done_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter; UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// pin falls one clock after a handshake; data_ready only in IDLE or the last stop-bit clock.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK  = 51_800_000,
    parameter int BAUD = 115200
) (
    input  logic     clk,
    input  logic     reset,
    output logic     pin,
    uart_tx_if.slave tx_if
);

    localparam int DIV = uart_div(CLK, BAUD);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx: clocks per bit (DIV) must be at least 2");
    end

    if (DATA_BITS != 8 || STOP_BITS != 1) begin : g_frame_check
        $error("uart_tx: only 8 data bits and 1 stop bit are supported");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 pin_q, pin_d;
    logic                 bit_done;
    logic                 hs;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign hs = tx_if.data_valid && tx_if.data_ready;

    uart_baud_counter #(
        .DIV(DIV)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .restart_i (hs),
        .bit_done_o(bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs) state_d = START;
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done && (idx_q == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                // A handshake in the final stop clock chains straight into the next start bit.
                if (hs) begin
                    state_d = START;
                end else if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (hs) begin
            shift_d = tx_if.data_byte;
        end else if ((state_q == DATA) && bit_done) begin
            shift_d = shift_q >> 1;
        end
        if (state_q == START) begin
            idx_d = '0;
        end else if ((state_q == DATA) && bit_done) begin
            idx_d = idx_q + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    assign par_d = hs ? (^tx_if.data_byte) : par_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_if.data_ready = (state_q == IDLE) || ((state_q == STOP) && bit_done);

    // The line level is decoded from the next state so the pin flop changes with the state.
    always_comb begin
        case (state_d)
            START:   pin_d = 1'b0;
            DATA:    pin_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  pin_d = par_d;
`endif
            default: pin_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_q <= 1'b1;
        end else begin
            pin_q <= pin_d;
        end
    end

    assign pin = pin_q;

endmodule
